axis_out_stream: RTL and testbench

- AXI-Stream master that carries FIR output samples from the fir_dataflow core to the testbench/downstream sink.
- Transmit-side counterpart of the stream input stage.
- Buffers results in a small FIFO so FIR back-pressure is decoupled from sm_tready.
- Counts beats against the programmed data_length, asserts sm_tlast on the final beat, and pulses axis_done when the frame is fully transmitted.

---
 rtl/axis_out_stream_if.sv | 24 ++
 rtl/axis_out_stream.sv | 136 +++++++++++++
 tb/tb_axis_out_stream.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_out_stream_if.sv
// AXI-Stream bundle between the FIR output stage and the sink.
// The master drives data/valid/last and the slave drives ready.
interface axis_out_stream_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_out_stream.sv
// FIR result streamer: buffers samples in a small FIFO and emits
// one AXI-Stream frame of data_length beats with tlast and done.
module axis_out_stream #(
    parameter int pDATA_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int pLEN_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ap_start,
    input  logic [pLEN_WIDTH-1:0]  data_length,
    input  logic [pDATA_WIDTH-1:0] fir_data,
    input  logic                   fir_valid,
    output logic                   fir_ready,
    axis_out_stream_if.master      sm,
    output logic                   axis_done,
    output logic                   busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [pDATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic [pLEN_WIDTH-1:0]  len_q;
    logic [pLEN_WIDTH-1:0]  in_cnt;
    logic [pLEN_WIDTH-1:0]  out_cnt;

    logic full;
    logic empty;
    logic start;
    logic push;
    logic pop;
    logic last_push;
    logic last_pop;
    logic streaming;

    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign start     = (state == IDLE) & ap_start;
    assign streaming = (state == RUN) | (state == DRAIN);

    // fir_ready depends only on local state, never on sm.tready
    assign fir_ready = (state == RUN) & ~full & (in_cnt < len_q);
    assign push      = fir_valid & fir_ready;
    assign last_push = push & ((in_cnt + pLEN_WIDTH'(1)) == len_q);

    assign sm.tvalid = ~empty & streaming;
    assign sm.tdata  = sm.tvalid ? mem[rd_ptr] : '0;
    assign sm.tlast  = sm.tvalid
                     & (out_cnt == (len_q - pLEN_WIDTH'(1)));
    assign pop       = sm.tvalid & sm.tready;
    assign last_pop  = pop & sm.tlast;

    assign axis_done = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (ap_start) begin
                    state_nx = (data_length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_push) state_nx = DRAIN;
            end
            DRAIN: begin
                if (last_pop) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (start) begin
            len_q   <= data_length;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (push) in_cnt  <= in_cnt + pLEN_WIDTH'(1);
            if (pop)  out_cnt <= out_cnt + pLEN_WIDTH'(1);
        end
    end

    // Depth is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fir_data;
    end

endmodule

// File: tb/tb_axis_out_stream.sv
// Randomized bench for axis_out_stream against a queue-based
// transaction model of the frame protocol.
module tb_axis_out_stream;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int LW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic [LW-1:0] data_length = '0;
    logic [W-1:0]  fir_data = '0;
    logic          fir_valid = 1'b0;
    logic          fir_ready;
    logic          axis_done;
    logic          busy;

    axis_out_stream_if #(.DW(W)) sm ();

    axis_out_stream #(
        .pDATA_WIDTH(W),
        .FIFO_DEPTH (D),
        .pLEN_WIDTH (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ap_start   (ap_start),
        .data_length(data_length),
        .fir_data   (fir_data),
        .fir_valid  (fir_valid),
        .fir_ready  (fir_ready),
        .sm         (sm),
        .axis_done  (axis_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mph_t;

    mph_t          mph = M_IDLE;
    logic [LW-1:0] mlen = '0;
    logic [LW-1:0] mpushed = '0;
    logic [LW-1:0] mpopped = '0;
    logic [W-1:0]  mq[$];
    logic [W-1:0]  tx[$];
    logic [W-1:0]  rx[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_push = 0;
    int n_last = 0;
    int n_done = 0;
    bit rnd_mode = 1'b0;

    task automatic chk(string tag, logic [63:0] got,
                       logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_data();
        if (rnd_mode) fir_data = $urandom;
        else          fir_data = fir_data + 1;
    endtask

    task automatic clear_sb();
        tx.delete();
        rx.delete();
        n_push = 0;
        n_last = 0;
        n_done = 0;
    endtask

    task automatic cycle(bit st, logic [LW-1:0] dl,
                         bit fv, bit rdy);
        bit er;
        bit ev;
        bit push;
        bit pop;
        bit lastp;
        logic [W-1:0] ed;
        @(negedge clk);
        er = (mph == M_RUN) && (mq.size() < D)
             && (mpushed < mlen);
        ev = (mq.size() > 0)
             && (mph == M_RUN || mph == M_DRAIN);
        ed = '0;
        if (ev) ed = mq[0];
        chk("fir_ready", fir_ready, er);
        chk("tvalid", sm.tvalid, ev);
        chk("tdata", sm.tdata, ed);
        chk("tlast", sm.tlast,
            ev && (mpopped == mlen - 1));
        chk("axis_done", axis_done, mph == M_DONE);
        chk("busy", busy, mph != M_IDLE);
        ap_start    = st;
        data_length = dl;
        fir_valid   = fv;
        sm.tready   = rdy;
        if (fir_valid && fir_ready) n_push++;
        if (sm.tvalid && sm.tready) begin
            rx.push_back(sm.tdata);
            if (sm.tlast) n_last++;
        end
        if (axis_done) n_done++;
        push  = fv && er;
        pop   = ev && rdy;
        lastp = pop && (mpopped == mlen - 1);
        case (mph)
            M_IDLE: if (st) begin
                mlen    = dl;
                mpushed = '0;
                mpopped = '0;
                mph     = (dl == 0) ? M_DONE : M_RUN;
            end
            M_RUN:   if (push && mpushed + 1 == mlen) mph = M_DRAIN;
            M_DRAIN: if (lastp) mph = M_DONE;
            M_DONE:  mph = M_IDLE;
            default: mph = M_IDLE;
        endcase
        if (pop) begin
            void'(mq.pop_front());
            mpopped++;
        end
        if (push) begin
            mq.push_back(fir_data);
            tx.push_back(fir_data);
            mpushed++;
        end
        @(posedge clk);
        #1;
        if (push) next_data();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_fir_ready", fir_ready, 0);
        chk("rst_tvalid", sm.tvalid, 0);
        chk("rst_tdata", sm.tdata, 0);
        chk("rst_tlast", sm.tlast, 0);
        chk("rst_axis_done", axis_done, 0);
        chk("rst_busy", busy, 0);
        mph     = M_IDLE;
        mlen    = '0;
        mpushed = '0;
        mpopped = '0;
        mq.delete();
        ap_start  = 1'b0;
        fir_valid = 1'b0;
        sm.tready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_seq(string tag, int n, int base);
        chk({tag, "_len"}, rx.size(), n);
        for (int i = 0; i < n && i < rx.size(); i++) begin
            chk({tag, "_data"}, rx[i], base + i);
        end
        chk({tag, "_tlast"}, n_last, 1);
        chk({tag, "_done"}, n_done, 1);
    endtask

    task automatic run_until_idle(int budget, bit fv, bit rdy);
        for (int i = 0; i < budget; i++) begin
            if (n_done > 0 && mph == M_IDLE) break;
            cycle(0, '0, fv, rdy);
        end
    endtask

    initial begin
        sm.tready = 1'b0;
        do_reset();

        // basic frame of 5
        clear_sb();
        fir_data = 1;
        cycle(1, 5, 0, 1);
        run_until_idle(20, 1, 1);
        check_seq("basic", 5, 1);

        // back-pressure stalls the FIR after 4 pushes
        clear_sb();
        fir_data = 1;
        cycle(1, 8, 0, 0);
        repeat (10) cycle(0, '0, 1, 0);
        chk("bp_pushes", n_push, 4);
        chk("bp_hold_data", sm.tdata, 1);
        chk("bp_hold_ready", fir_ready, 0);
        run_until_idle(40, 1, 1);
        check_seq("bp", 8, 1);

        // long random frame
        clear_sb();
        rnd_mode = 1'b1;
        fir_data = $urandom;
        cycle(1, 600, 0, 0);
        for (int i = 0; i < 8000; i++) begin
            if (n_done > 0 && mph == M_IDLE) break;
            cycle(0, '0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        chk("rnd_len", rx.size(), 600);
        chk("rnd_tx_len", tx.size(), 600);
        for (int i = 0; i < rx.size() && i < tx.size(); i++) begin
            chk("rnd_data", rx[i], tx[i]);
        end
        chk("rnd_tlast", n_last, 1);
        chk("rnd_done", n_done, 1);
        rnd_mode = 1'b0;

        // zero-length frame
        clear_sb();
        cycle(1, 0, 1, 1);
        repeat (4) cycle(0, '0, 1, 1);
        chk("zero_done", n_done, 1);
        chk("zero_beats", rx.size(), 0);
        chk("zero_pushes", n_push, 0);

        // reset with two samples buffered after three beats
        clear_sb();
        fir_data = 1;
        cycle(1, 10, 0, 0);
        repeat (2) cycle(0, '0, 1, 0);
        repeat (3) cycle(0, '0, 1, 1);
        chk("mid_beats", rx.size(), 3);
        chk("mid_fill", mq.size(), 2);
        do_reset();
        clear_sb();
        fir_data = 100;
        cycle(1, 2, 0, 1);
        run_until_idle(20, 1, 1);
        check_seq("after_rst", 2, 100);

        // ap_start during RUN is ignored
        clear_sb();
        fir_data = 1;
        cycle(1, 6, 0, 1);
        cycle(0, '0, 1, 1);
        cycle(1, 3, 1, 1);
        run_until_idle(30, 1, 1);
        check_seq("restart", 6, 1);

        repeat (3) cycle(0, '0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
